aes_arbiter2: RTL and testbench

AES_ARBITER2 -- requirements
Module: aes_arbiter2

---
 rtl/aes_arbiter2.sv | 164 ++++++++++++++++
 tb/tb_aes_arbiter2.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_arbiter2.sv
// rtl/aes_arbiter2.sv - two-requester front end sharing one AES-128 core
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   reqN_valid/ready/key/pt       block submission from requester N (N = 0, 1)
//   rspN_valid/ready/ct           ciphertext return to requester N
//   hold_step                     stall; core_step_en is its inverse
//   core_start/key/plaintext      launch of one block on the shared core
//   core_step_en                  round-advance enable to the core
//   core_busy/done/ciphertext     core status and result
//   err                           sticky watchdog timeout flag
module aes_arbiter2 #(
    parameter int WATCHDOG_MAX = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [127:0] req0_key,
    input  logic [127:0] req0_pt,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [127:0] req1_key,
    input  logic [127:0] req1_pt,
    output logic         rsp0_valid,
    input  logic         rsp0_ready,
    output logic [127:0] rsp0_ct,
    output logic         rsp1_valid,
    input  logic         rsp1_ready,
    output logic [127:0] rsp1_ct,
    input  logic         hold_step,
    output logic         core_start,
    output logic [127:0] core_key,
    output logic [127:0] core_plaintext,
    output logic         core_step_en,
    input  logic         core_busy,
    input  logic         core_done,
    input  logic [127:0] core_ciphertext,
    output logic         err
);

    // The counter only has to reach WATCHDOG_MAX-1; the final step is
    // detected combinationally so the timeout lands on the MAX-th step.
    localparam int WD_W = (WATCHDOG_MAX < 2) ? 1 : $clog2(WATCHDOG_MAX);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WATCHDOG_MAX - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_n;
    logic            prio;
    logic            gidx;
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
    logic [127:0]    op_key;
    logic [127:0]    op_pt;
    logic [127:0]    rsp_q;

    logic grant;
    logic idle_free;
    logic accept;
    logic capture;
    logic timeout;
    logic wd_step;
    logic rsp_hs;
    logic rsp_on;

    // Priority pointer only matters on contention; otherwise the lone
    // valid requester wins (requester 0 when nobody is asking).
    assign grant     = (req0_valid && req1_valid) ? prio : req1_valid;
    assign idle_free = (state == IDLE) && !core_busy;

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        wd_step = 1'b0;
        rsp_hs  = 1'b0;
        case (state)
            IDLE: begin
                if (idle_free && (grant ? req1_valid : req0_valid)) begin
                    accept  = 1'b1;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: state_n = RUN;
            RUN: begin
                // A done in the same cycle as the last allowed step wins.
                if (core_done) begin
                    capture = 1'b1;
                    state_n = RESP;
                end else if (core_step_en) begin
                    wd_step = 1'b1;
                    if (wd_cnt == WD_LAST) begin
                        timeout = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            RESP: begin
                if (gidx ? rsp1_ready : rsp0_ready) begin
                    rsp_hs  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            prio   <= 1'b0;
            gidx   <= 1'b0;
            wd_cnt <= '0;
            err_q  <= 1'b0;
            op_key <= '0;
            op_pt  <= '0;
            rsp_q  <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                gidx   <= grant;
                op_key <= grant ? req1_key : req0_key;
                op_pt  <= grant ? req1_pt : req0_pt;
                wd_cnt <= '0;
            end
            if (wd_step) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (capture) begin
                rsp_q <= core_ciphertext;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (rsp_hs) begin
                prio <= ~gidx;
            end
        end
    end

    // Outputs are gated by rst so they read zero during the reset cycle
    // itself, before the registers have been cleared.
    assign rsp_on         = !rst && (state == RESP);
    assign req0_ready     = !rst && idle_free && !grant;
    assign req1_ready     = !rst && idle_free && grant;
    assign rsp0_valid     = rsp_on && !gidx;
    assign rsp1_valid     = rsp_on && gidx;
    assign rsp0_ct        = rsp0_valid ? rsp_q : '0;
    assign rsp1_ct        = rsp1_valid ? rsp_q : '0;
    assign core_start     = !rst && (state == LAUNCH);
    assign core_key       = rst ? '0 : op_key;
    assign core_plaintext = rst ? '0 : op_pt;
    assign core_step_en   = !hold_step;
    assign err            = err_q && !rst;

endmodule

// File: tb/tb_aes_arbiter2.sv
// tb/tb_aes_arbiter2.sv - self-checking bench for aes_arbiter2 with a behavioural AES core
module tb_aes_arbiter2;

    localparam int WD = 16;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         v0 = 0, v1 = 0, r0 = 1, r1 = 1, hold = 0, inject = 0;
    logic [127:0] k0 = '0, p0 = '0, k1 = '0, p1 = '0;
    logic         req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [127:0] rsp0_ct, rsp1_ct, core_key, core_plaintext, core_ciphertext;
    logic         core_start, core_step_en, core_busy, core_done, err;

    aes_arbiter2 dut (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_ready(req0_ready), .req0_key(k0), .req0_pt(p0),
        .req1_valid(v1), .req1_ready(req1_ready), .req1_key(k1), .req1_pt(p1),
        .rsp0_valid(rsp0_valid), .rsp0_ready(r0), .rsp0_ct(rsp0_ct),
        .rsp1_valid(rsp1_valid), .rsp1_ready(r1), .rsp1_ct(rsp1_ct),
        .hold_step(hold),
        .core_start(core_start), .core_key(core_key), .core_plaintext(core_plaintext),
        .core_step_en(core_step_en), .core_busy(core_busy), .core_done(core_done),
        .core_ciphertext(core_ciphertext), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- AES-128 reference ----------------
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b, s, r;
        for (int x = 1; x < 256; x++) begin end
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            s = b ^ 8'h63;
            r = b;
            for (int n = 0; n < 4; n++) begin
                r = {r[6:0], r[7]};
                s = s ^ r;
            end
            sbox[x] = s;
        end
    endtask

    function automatic logic [127:0] aes128(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   rc = 8'h01;
        logic [31:0]  tmp;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] out;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
        return out;
    endfunction

    // ---------------- behavioural core: done on the core_len-th enabled step ----------------
    int           core_len = 11;
    logic         cbusy = 1'b0;
    int           ccnt = 0;
    logic [127:0] cct = '0;

    always @(posedge clk) begin
        if (rst) begin
            cbusy <= 1'b0;
            ccnt  <= 0;
        end else if (core_start && !cbusy) begin
            cbusy <= 1'b1;
            ccnt  <= 0;
            cct   <= aes128(core_key, core_plaintext);
        end else if (cbusy && core_step_en) begin
            if (ccnt == core_len - 1) cbusy <= 1'b0;
            else ccnt <= ccnt + 1;
        end
    end
    assign core_busy       = cbusy;
    assign core_done       = (cbusy && core_step_en && ccnt == core_len - 1) || inject;
    assign core_ciphertext = cct;

    // ---------------- transaction-level reference model ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit           in_flight = 0, resp_due = 0, prio_m = 0, err_m = 0;
    bit           acc0_last = 0, acc1_last = 0;
    int           since = 0, steps = 0, idx = 0, last_idx = 0;
    int           acc_count = 0, rsp_count = 0, acc_cyc = 0, rsp_cyc = 0, hs_cyc = 0;
    logic [127:0] exp_ct = '0, exp_key = '0, exp_pt = '0, dut_ct_first = '0;
    int           grants[$];

    always @(negedge clk) begin : mon
        logic e_r0, e_r1, g;
        bit   was_due;
        acc0_last = 0;
        acc1_last = 0;
        if (rst) begin
            check("rst_ready", {req0_ready, req1_ready}, 0);
            check("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
            check("rst_rsp_ct", rsp0_ct | rsp1_ct, 0);
            check("rst_core_start", core_start, 0);
            check("rst_core_op", core_key | core_plaintext, 0);
            in_flight = 0; resp_due = 0; prio_m = 0; err_m = 0;
        end else begin
            if (in_flight) since++;
            check("step_en", core_step_en, !hold);
            check("core_start", core_start, in_flight && since == 1);
            if (in_flight && since == 1) begin
                check("core_key", core_key, exp_key);
                check("core_pt", core_plaintext, exp_pt);
            end
            was_due = in_flight && resp_due;
            check("rsp0_valid", rsp0_valid, was_due && idx == 0);
            check("rsp1_valid", rsp1_valid, was_due && idx == 1);
            check("rsp0_ct", rsp0_ct, (was_due && idx == 0) ? exp_ct : '0);
            check("rsp1_ct", rsp1_ct, (was_due && idx == 1) ? exp_ct : '0);
            check("err", err, err_m);
            g    = (v0 && v1) ? prio_m : v1;
            e_r0 = !in_flight && !cbusy && !g;
            e_r1 = !in_flight && !cbusy && g;
            check("req0_ready", req0_ready, e_r0);
            check("req1_ready", req1_ready, e_r1);
            if (was_due) begin
                if (cyc == rsp_cyc) begin
                    dut_ct_first = (idx == 0) ? rsp0_ct : rsp1_ct;
                    last_idx = idx;
                end
                if (idx == 0 ? r0 : r1) begin
                    in_flight = 0;
                    prio_m = (idx == 0);
                    rsp_count++;
                    hs_cyc = cyc;
                end
            end else if (in_flight && since >= 2 && !hold) begin
                steps++;
                if (steps == core_len) begin
                    resp_due = 1;
                    rsp_cyc = cyc + 1;
                end else if (steps == WD) begin
                    err_m = 1;
                    in_flight = 0;
                end
            end
            if ((v0 && e_r0) || (v1 && e_r1)) begin
                idx = (v0 && e_r0) ? 0 : 1;
                exp_key = idx ? k1 : k0;
                exp_pt  = idx ? p1 : p0;
                exp_ct  = aes128(exp_key, exp_pt);
                in_flight = 1; resp_due = 0; since = 0; steps = 0;
                acc_count++;
                acc_cyc = cyc;
                grants.push_back(idx);
                if (idx == 0) acc0_last = 1; else acc1_last = 1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input string tag, input int n0);
        for (int i = 0; i < 80 && acc_count == n0; i++) tick();
        if (acc_count == n0) check(tag, 0, 1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300 && (in_flight || cbusy); i++) tick();
        if (in_flight || cbusy) check(tag, 0, 1);
    endtask

    logic [127:0] key4, pt4, first;
    int           a, t_err, rc_before;

    initial begin
        build_sbox();
        repeat (3) tick();
        rst = 0;
        tick();

        // single request, FIPS-197 vector
        k0 = FIPS_K; p0 = FIPS_P; v0 = 1;
        wait_acc("s1_acc", acc_count);
        v0 = 0;
        wait_idle("s1_idle");
        check("s1_latency", rsp_cyc - acc_cyc, 13);
        check("s1_ct", dut_ct_first, FIPS_C);
        check("s1_idx", last_idx, 0);

        // contention from reset, both held valid
        rst = 1; grants.delete();
        k0 = {4{$urandom}}; p0 = {4{$urandom}}; k1 = {4{$urandom}}; p1 = {4{$urandom}};
        v0 = 1; v1 = 1;
        repeat (2) tick();
        rst = 0;
        for (int i = 0; i < 300 && grants.size() < 4; i++) tick();
        v0 = 0; v1 = 0;
        if (grants.size() < 4) check("s2_timeout", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++)
            check($sformatf("s2_grant%0d", i), grants[i], i % 2);
        wait_idle("s2_idle");

        // stall for 5 cycles during RUN
        k0 = FIPS_K; p0 = FIPS_P; v0 = 1;
        wait_acc("s3_acc", acc_count);
        v0 = 0;
        repeat (3) tick();
        hold = 1;
        repeat (5) tick();
        hold = 0;
        wait_idle("s3_idle");
        check("s3_latency", rsp_cyc - acc_cyc, 18);
        check("s3_ct", dut_ct_first, FIPS_C);
        check("s3_err", err, 0);

        // response backpressure with req1 waiting
        r0 = 0; key4 = {4{$urandom}}; pt4 = {4{$urandom}};
        k0 = key4; p0 = pt4; v0 = 1;
        wait_acc("s4_acc", acc_count);
        v0 = 0; v1 = 1;
        for (int i = 0; i < 40 && !(in_flight && resp_due); i++) tick();
        first = rsp0_ct;
        check("s4_ct", first, aes128(key4, pt4));
        for (int i = 0; i < 7; i++) begin
            check("s4_stable", rsp0_ct, first);
            check("s4_req1_held", req1_ready, 0);
            tick();
        end
        r0 = 1;
        wait_acc("s4_acc1", acc_count);
        v1 = 0;
        check("s4_order", acc_cyc > hs_cyc, 1);
        check("s4_idx", grants[grants.size()-1], 1);
        wait_idle("s4_idle");

        // watchdog timeout with a core that takes too long
        core_len = 40; rc_before = rsp_count;
        k0 = {4{$urandom}}; v0 = 1;
        wait_acc("s5_acc", acc_count);
        v0 = 0; a = acc_cyc; v1 = 1;
        for (int i = 0; i < 60 && !err; i++) tick();
        t_err = cyc;
        check("s5_err_latency", t_err - a, WD + 2);
        wait_acc("s5_acc1", acc_count);
        v1 = 0;
        check("s5_regrant_cycle", acc_cyc - a, 42);
        check("s5_norsp", rsp_count, rc_before);
        check("s5_sticky", err, 1);
        wait_idle("s5_idle");
        core_len = 11;

        // reset during RUN, then a fresh block
        k0 = {4{$urandom}}; v0 = 1;
        wait_acc("s6_acc", acc_count);
        v0 = 0;
        repeat (5) tick();
        rc_before = rsp_count;
        rst = 1;
        tick();
        rst = 0;
        tick();
        check("s6_err_cleared", err, 0);
        k1 = FIPS_K; p1 = FIPS_P; v1 = 1;
        wait_acc("s6_acc1", acc_count);
        v1 = 0;
        wait_idle("s6_idle");
        check("s6_latency", rsp_cyc - acc_cyc, 13);
        check("s6_ct", dut_ct_first, FIPS_C);
        check("s6_idx", last_idx, 1);
        check("s6_rsp_count", rsp_count, rc_before + 1);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            if (acc0_last || !v0) v0 = ($urandom % 3) != 0;
            else if ($urandom % 8 == 0) v0 = 0;
            if (acc1_last || !v1) v1 = ($urandom % 3) != 0;
            else if ($urandom % 8 == 0) v1 = 0;
            k0 = {$urandom, $urandom, $urandom, $urandom};
            p0 = {$urandom, $urandom, $urandom, $urandom};
            k1 = {$urandom, $urandom, $urandom, $urandom};
            p1 = {$urandom, $urandom, $urandom, $urandom};
            hold = ($urandom % 4) == 0;
            r0 = ($urandom % 3) != 0;
            r1 = ($urandom % 3) != 0;
            inject = (($urandom % 6) == 0) && (!in_flight || resp_due);
            tick();
        end
        v0 = 0; v1 = 0; hold = 0; r0 = 1; r1 = 1; inject = 0;
        wait_idle("rand_drain");
        check("rand_served", rsp_count > 20, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
